// File: rtl/obs_hist_builder_pkg.sv
// Shared constants and types for the observation histogram builder and the
// chi-squared detector that reads its bins.
package ids_pkg;

    // Bin address width and the number of bins it spans (one per byte value).
    localparam int ADDR_W = 8;
    localparam int NUM_BINS = 256;

    // Default bin counter width, matching the reader's O_in width.
    localparam int DEF_CNT_W = 16;

    // Detector decision threshold on the chi-squared statistic
    // (approx. 5% critical value for 255 degrees of freedom).
    localparam int THRESHOLD = 293;

    // Histogram builder sequencing.
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        COUNT = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } hist_state_t;

endpackage

// File: rtl/obs_hist_builder_if.sv
// Sample stream and histogram reader port of the histogram builder.
//
// Handshake: a sample transfers on a rising edge where sym_valid and
// sym_ready are both high; sym_in must be stable while sym_valid is high.
// The reader drives rd_addr and sees the bin count on rd_data one cycle
// later while data_rdy is high, then pulses done for one cycle to release
// the histogram.
interface obs_hist_builder_if #(
    parameter int CNT_W = ids_pkg::DEF_CNT_W
);
    import ids_pkg::*;

    logic              sym_valid;
    logic [ADDR_W-1:0] sym_in;
    logic              sym_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  rd_data;
    logic              data_rdy;
    logic              done;

    modport master (
        output sym_valid, sym_in, rd_addr, done,
        input  sym_ready, rd_data, data_rdy
    );

    modport slave (
        input  sym_valid, sym_in, rd_addr, done,
        output sym_ready, rd_data, data_rdy
    );

endinterface

// File: rtl/obs_hist_builder_hist_ram.sv
// Bin storage: one synchronous write port and two synchronous read ports
// (increment path and external reader). No reset, so it maps onto block RAM.
module hist_ram
    import ids_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Both read ports return the contents before a same-edge write.
    always_ff @(posedge clk) begin
        ra_data <= mem[ra_addr];
        rb_data <= mem[rb_addr];
    end

endmodule

// File: rtl/obs_hist_builder.sv
// Builds a 256-bin histogram of WINDOW accepted symbols, holds it for a
// reader, then clears itself for the next window.
module obs_hist_builder
    import ids_pkg::*;
#(
    parameter int WINDOW = 256,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    obs_hist_builder_if.slave   bus,
    output hist_state_t         state_dbg
);

    localparam logic [15:0]      LAST_IDX = 16'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    hist_state_t       state, state_nxt;
    logic [ADDR_W-1:0] sweep;
    logic [15:0]       sample_cnt;
    logic              accept;

    // Second stage of the read-modify-write.
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_fwd;
    logic [CNT_W-1:0]  last_wdata;

    // Reader port bypass for a write landing on the same edge as its read.
    logic              rdb_fwd;
    logic [CNT_W-1:0]  rdb_fwd_data;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [CNT_W-1:0]  ram_wdata, ram_qa, ram_qb, base, bumped;

    assign accept    = bus.sym_valid && (state == COUNT);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; done is only honoured once in HOLD.
    always_comb begin
        state_nxt     = state;
        bus.sym_ready = 1'b0;
        bus.data_rdy  = 1'b0;
        case (state)
            CLEAR: if (sweep == ADDR_W'(NUM_BINS - 1)) state_nxt = COUNT;
            COUNT: begin
                bus.sym_ready = 1'b1;
                if (bus.sym_valid && (sample_cnt == LAST_IDX)) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = HOLD;
            HOLD: begin
                bus.data_rdy = 1'b1;
                if (bus.done) state_nxt = CLEAR;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Clear sweep address and per-window sample count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep      <= '0;
            sample_cnt <= '0;
        end else if (state == CLEAR) begin
            sweep      <= sweep + ADDR_W'(1);
            sample_cnt <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end

    // Pipeline registers: pending increment, its forwarding flag and the
    // reader-port bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid   <= 1'b0;
            pend_addr    <= '0;
            pend_fwd     <= 1'b0;
            last_wdata   <= '0;
            rdb_fwd      <= 1'b0;
            rdb_fwd_data <= '0;
        end else begin
            pend_valid   <= accept;
            pend_addr    <= bus.sym_in;
            // The RAM read issued this edge misses the write issued on the
            // same edge, so remember to take that written value instead.
            pend_fwd     <= pend_valid && (pend_addr == bus.sym_in);
            last_wdata   <= bumped;
            rdb_fwd      <= ram_we && (ram_waddr == bus.rd_addr);
            rdb_fwd_data <= ram_wdata;
        end
    end

    // Saturating increment and write-port steering (clear sweep has priority).
    always_comb begin
        base      = pend_fwd ? last_wdata : ram_qa;
        bumped    = (base == CNT_MAX) ? base : base + CNT_W'(1);
        ram_we    = 1'b0;
        ram_waddr = pend_addr;
        ram_wdata = bumped;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = sweep;
            ram_wdata = '0;
        end else if (pend_valid) begin
            ram_we = 1'b1;
        end
    end

    // Reader output: registered bin value while holding, zero otherwise.
    always_comb begin
        bus.rd_data = '0;
        if (state == HOLD) begin
            bus.rd_data = rdb_fwd ? rdb_fwd_data : ram_qb;
        end
    end

    hist_ram #(
        .AW (ADDR_W),
        .DW (CNT_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .ra_addr (bus.sym_in),
        .ra_data (ram_qa),
        .rb_addr (bus.rd_addr),
        .rb_data (ram_qb)
    );

endmodule

// File: doc/obs_hist_builder.md
OBS_HIST_BUILDER -- requirements
Module: obs_hist_builder

Interface
REQ-001 Parameter WINDOW, default 256: number of samples accepted per observation window (1..65535).
REQ-002 Parameter CNT_W, default 16: bin counter width; equals the O_in width of the chi-squared reader.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset: asynchronous, active-high.
REQ-005 sym_valid  input  1  sample symbol present on sym_in.
REQ-006 sym_in  input  8  sample symbol (bin index 0..255).
REQ-007 sym_ready  output  1  block accepts sym_in this cycle; a transfer occurs when sym_valid and sym_ready are both high.
REQ-008 rd_addr  input  8  bin address driven by the reader (chi-squared addrb).
REQ-009 rd_data  output  CNT_W  bin count for rd_addr; registered, valid one cycle after rd_addr.
REQ-010 data_rdy  output  1  completed histogram held and readable.
REQ-011 done  input  1  single-cycle pulse from the reader: histogram consumed.

Function
REQ-012 The FSM SHALL have four states: CLEAR, COUNT, DRAIN and HOLD.
REQ-013 CLEAR SHALL write zero to bins 0..255, one bin per cycle, using a sweep counter, and SHALL enter COUNT after bin 255 (256 cycles).
REQ-014 In CLEAR the sample counter SHALL be zeroed and sym_ready SHALL be 0.
REQ-015 sym_ready SHALL be 1 only in COUNT.
REQ-016 Each accepted sample SHALL increment bin[sym_in] by exactly 1 through a 2-stage read-modify-write: RAM read in the accept cycle, write of count+1 on the next cycle.
REQ-017 Back-to-back accepts of the same symbol SHALL forward the pending write value, so N consecutive identical samples yield a count of N; no stall is permitted and throughput is 1 sample per cycle.
REQ-018 Increments SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-019 On acceptance of the WINDOW-th sample, COUNT SHALL go to DRAIN for one cycle to complete the pending write, then to HOLD.
REQ-020 data_rdy SHALL be 1 exactly while in HOLD, first asserted 2 cycles after the final accept.
REQ-021 In HOLD, rd_data SHALL equal bin[rd_addr] sampled on the previous edge.
REQ-022 Outside HOLD, rd_data SHALL be 0.
REQ-023 done in HOLD SHALL move the FSM to CLEAR; data_rdy SHALL drop on the next cycle.
REQ-024 done outside HOLD SHALL be ignored.
REQ-025 sym_valid outside COUNT SHALL be ignored; no sample is dropped silently while sym_ready is 1.
REQ-026 done arriving on the same edge as entry to HOLD SHALL have no effect; only a done sampled while already in HOLD counts.

Reset
REQ-027 rst SHALL force the state to CLEAR, sweep and sample counters to 0, pending-write valid to 0, and data_rdy, sym_ready and rd_data to 0.
REQ-028 rst asserted mid-COUNT or mid-HOLD SHALL abandon the window; after release a full 256-cycle clear runs before any sample is accepted.
REQ-029 RAM contents SHALL not be reset directly; the CLEAR sweep provides initialisation.

Structure
REQ-030 The state enum, ADDR_W=8, the bin count 256 and the default CNT_W SHALL live in shared package ids_pkg, together with the detector THRESHOLD constant.
REQ-031 Storage SHALL be a sub-module hist_ram: simple dual-port 256xCNT_W RAM with a synchronous write port and two synchronous read ports (RMW read and reader read), inferable as block RAM.
REQ-032 The implementation SHALL be 120-400 lines excluding hist_ram.

Verification
REQ-033 Reset release, WINDOW=256, 256 samples 0..255 streamed with sym_valid=1 -> sym_ready rises 256 cycles after reset; data_rdy rises 2 cycles after the final accept; every bin reads 1.
REQ-034 256 consecutive samples of 0x2A -> bin 0x2A reads 256, all other bins read 0 (checks forwarding).
REQ-035 Alternating 0x05,0x05,0x07 pattern with random sym_valid gaps -> counts match the scoreboard; sym_ready is never low in COUNT.
REQ-036 CNT_W=4, WINDOW=20, 20 samples of 0x01 -> bin 0x01 reads 15 (saturation).
REQ-037 done pulse in HOLD -> data_rdy low next cycle; after 256 clear cycles a new window starts and all bins read 0 before the new samples are applied.
REQ-038 rst pulse after 100 of 256 samples -> outputs return to 0, full clear runs, and the next window's counts exclude the abandoned samples.
